// File: rtl/noc_link_sender.sv
// Output link stage: drains the local circular buffer onto one inter-router link
// under downstream on/off flow control, tracks packet framing and keeps debug counters.
module noc_link_sender #(
    parameter int unsigned FLIT_W = 34,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [FLIT_W-1:0] buf_data_i,
    input  logic              buf_empty_i,
    output logic              buf_read_o,
    input  logic              dn_on_off_i,
    output logic              link_valid_o,
    output logic [FLIT_W-1:0] link_flit_o,
    output logic              pkt_active_o,
    output logic              proto_err_o,
    input  logic              clear_i,
    output logic [CNT_W-1:0]  flit_cnt_o,
    output logic [CNT_W-1:0]  pkt_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0]       FT_HEAD = 2'b00;
    localparam logic [1:0]       FT_BODY = 2'b01;
    localparam logic [1:0]       FT_TAIL = 2'b10;
    localparam logic [1:0]       FT_HT   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       dn_on_q;
    logic       pop;
    logic       stall;
    logic       frame_err;
    logic       pkt_done;
    logic [1:0] ftype;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    assign ftype      = buf_data_i[FLIT_W-1 -: 2];
    assign pop        = enable_i & ~buf_empty_i & dn_on_q & ~rst;
    assign buf_read_o = pop;
    assign stall      = enable_i & ~buf_empty_i & ~dn_on_q;
    assign pkt_done   = pop & ((ftype == FT_TAIL) | (ftype == FT_HT));

    // Framing FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Framing FSM: next state and framing check, evaluated only on a pop
    always_comb begin
        state_d   = state_q;
        frame_err = 1'b0;
        if (pop) begin
            case (ftype)
                FT_HEAD: begin frame_err = (state_q == ACTIVE); state_d = ACTIVE; end
                FT_BODY: begin frame_err = (state_q == IDLE);   state_d = ACTIVE; end
                FT_TAIL: begin frame_err = (state_q == IDLE);   state_d = IDLE;   end
                FT_HT:   begin frame_err = (state_q == ACTIVE); state_d = IDLE;   end
                default: ;
            endcase
        end
    end

    // Framing FSM: outputs
    always_comb begin
        pkt_active_o = 1'b0;
        if (state_q == ACTIVE) pkt_active_o = 1'b1;
    end

    // Link register; flit holds when nothing is popped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_on_q      <= 1'b0;
            link_valid_o <= 1'b0;
            link_flit_o  <= '0;
        end else begin
            dn_on_q      <= dn_on_off_i;
            link_valid_o <= pop;
            if (pop) link_flit_o <= buf_data_i;
        end
    end

    // Sticky error flag and saturating statistics; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_o <= 1'b0;
            flit_cnt_o  <= '0;
            pkt_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else if (clear_i) begin
            proto_err_o <= 1'b0;
            flit_cnt_o  <= '0;
            pkt_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (frame_err) proto_err_o <= 1'b1;
            flit_cnt_o  <= sat_inc(flit_cnt_o, pop);
            pkt_cnt_o   <= sat_inc(pkt_cnt_o, pkt_done);
            stall_cnt_o <= sat_inc(stall_cnt_o, stall);
        end
    end

endmodule

// File: tb/tb_noc_link_sender.sv
// Self-checking bench for noc_link_sender: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model; a CNT_W=4 copy checks saturation.
module tb_noc_link_sender;

    localparam int unsigned FLIT_W = 34;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT4_W = 4;
    localparam int          SAT16  = 65535;
    localparam int          SAT4   = 15;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              enable    = 1'b0;
    logic              buf_empty = 1'b1;
    logic              dn_on_off = 1'b0;
    logic              clear     = 1'b0;
    logic [FLIT_W-1:0] buf_data  = '0;

    logic              buf_read, link_valid, pkt_active, proto_err;
    logic [FLIT_W-1:0] link_flit;
    logic [CNT_W-1:0]  flit_cnt, pkt_cnt, stall_cnt;

    logic              buf_read4, link_valid4, pkt_active4, proto_err4;
    logic [FLIT_W-1:0] link_flit4;
    logic [CNT4_W-1:0] flit_cnt4, pkt_cnt4, stall_cnt4;

    noc_link_sender #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .buf_data_i(buf_data),
        .buf_empty_i(buf_empty), .buf_read_o(buf_read), .dn_on_off_i(dn_on_off),
        .link_valid_o(link_valid), .link_flit_o(link_flit), .pkt_active_o(pkt_active),
        .proto_err_o(proto_err), .clear_i(clear), .flit_cnt_o(flit_cnt),
        .pkt_cnt_o(pkt_cnt), .stall_cnt_o(stall_cnt)
    );

    noc_link_sender #(.FLIT_W(FLIT_W), .CNT_W(CNT4_W)) dut4 (
        .clk(clk), .rst(rst), .enable_i(enable), .buf_data_i(buf_data),
        .buf_empty_i(buf_empty), .buf_read_o(buf_read4), .dn_on_off_i(dn_on_off),
        .link_valid_o(link_valid4), .link_flit_o(link_flit4), .pkt_active_o(pkt_active4),
        .proto_err_o(proto_err4), .clear_i(clear), .flit_cnt_o(flit_cnt4),
        .pkt_cnt_o(pkt_cnt4), .stall_cnt_o(stall_cnt4)
    );

    always #5 clk = ~clk;

    // Reference model: buffer contents as a queue, packet state as "inside a packet"
    logic [FLIT_W-1:0] q[$];
    logic              m_dn, m_valid, m_in_pkt, m_err;
    logic [FLIT_W-1:0] m_flit;
    int                m_fc, m_pc, m_sc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              en, dn, clr;
        logic              rd, valid, active;
        logic [FLIT_W-1:0] flit;
    } vec_t;

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    function automatic int clamp(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        chk("link_valid", link_valid, m_valid);
        chk("link_flit", link_flit, m_flit);
        chk("pkt_active", pkt_active, m_in_pkt);
        chk("proto_err", proto_err, m_err);
        chk("flit_cnt", flit_cnt, clamp(m_fc, SAT16));
        chk("pkt_cnt", pkt_cnt, clamp(m_pc, SAT16));
        chk("stall_cnt", stall_cnt, clamp(m_sc, SAT16));
        chk("link_valid4", link_valid4, m_valid);
        chk("link_flit4", link_flit4, m_flit);
        chk("pkt_active4", pkt_active4, m_in_pkt);
        chk("proto_err4", proto_err4, m_err);
        chk("flit_cnt4", flit_cnt4, clamp(m_fc, SAT4));
        chk("pkt_cnt4", pkt_cnt4, clamp(m_pc, SAT4));
        chk("stall_cnt4", stall_cnt4, clamp(m_sc, SAT4));
    endtask

    // Asserted at a falling edge; outputs must drop without waiting for a clock
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        m_dn = 0; m_valid = 0; m_flit = '0; m_in_pkt = 0; m_err = 0;
        m_fc = 0; m_pc = 0; m_sc = 0;
        chk("rst_buf_read", buf_read, 1'b0);
        chk("rst_buf_read4", buf_read4, 1'b0);
        check_regs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at the falling edge, check pop strobe, update model at the rise, check registers
    task automatic cycle(input logic en, input logic dn, input logic clr, output logic rd);
        logic              exp_rd, stall, starts, ends;
        logic [1:0]        t;
        logic [FLIT_W-1:0] head;
        enable    = en;
        dn_on_off = dn;
        clear     = clr;
        buf_empty = (q.size() == 0);
        head      = (q.size() != 0) ? q[0] : '0;
        buf_data  = head;
        #1;
        rd     = buf_read;
        exp_rd = en && (q.size() != 0) && m_dn;
        stall  = en && (q.size() != 0) && !m_dn;
        chk("buf_read", buf_read, exp_rd);
        chk("buf_read4", buf_read4, exp_rd);
        @(posedge clk);
        t      = head[FLIT_W-1 -: 2];
        starts = (t == 2'b00) || (t == 2'b11);
        ends   = (t == 2'b10) || (t == 2'b11);
        if (clr) begin
            m_fc = 0; m_pc = 0; m_sc = 0; m_err = 0;
        end else begin
            if (exp_rd) begin
                m_fc++;
                if (ends) m_pc++;
                if (starts == m_in_pkt) m_err = 1;
            end
            if (stall) m_sc++;
        end
        m_valid = exp_rd;
        if (exp_rd) begin
            m_flit   = head;
            m_in_pkt = !ends;
            void'(q.pop_front());
        end
        m_dn = dn;
        @(negedge clk);
        check_regs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              tv[6];
        logic              rd;
        logic [FLIT_W-1:0] fh, fb1, fb2, ft;
        fh  = mk(2'b00, 32'h0000_00A0);
        fb1 = mk(2'b01, 32'h0000_00B1);
        fb2 = mk(2'b01, 32'h0000_00B2);
        ft  = mk(2'b10, 32'h0000_00C3);
        tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, fh};
        tv[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, fb1};
        tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, fb2};
        tv[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ft};
        tv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ft};

        @(negedge clk);

        // H,B,B,T with permission from the first cycle
        q = {fh, fb1, fb2, ft};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(tv[i].en, tv[i].dn, tv[i].clr, rd);
            chk("tv_rd", rd, tv[i].rd);
            chk("tv_valid", link_valid, tv[i].valid);
            chk("tv_flit", link_flit, tv[i].flit);
            chk("tv_active", pkt_active, tv[i].active);
        end
        chk("t1_flit_cnt", flit_cnt, 4);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        chk("t1_stall_cnt", stall_cnt, 1);
        chk("t1_err", proto_err, 1'b0);

        // Six head-tail flits, downstream stops on the 4th pop and resumes 5 cycles later
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(mk(2'b11, 32'(i)));
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, rd);
        cycle(1'b1, 1'b0, 1'b0, rd);
        chk("onoff_last_pop", rd, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, rd);
            chk("onoff_stopped", rd, 1'b0);
        end
        chk("onoff_sent_before", flit_cnt, 4);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("onoff_rise_no_pop", rd, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, rd);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("onoff_flit_cnt", flit_cnt, 6);
        chk("onoff_pkt_cnt", pkt_cnt, 6);
        chk("onoff_stall_cnt", stall_cnt, 6);

        // Body first after reset, then clear
        q.delete();
        q.push_back(fb1);
        apply_reset();
        cycle(1'b1, 1'b1, 1'b0, rd);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("bfirst_err", proto_err, 1'b1);
        chk("bfirst_active", pkt_active, 1'b1);
        chk("bfirst_flit", link_flit, fb1);
        cycle(1'b1, 1'b1, 1'b1, rd);
        chk("clear_err", proto_err, 1'b0);
        chk("clear_flit_cnt", flit_cnt, 0);
        chk("clear_stall_cnt", stall_cnt, 0);
        chk("clear_keeps_fsm", pkt_active, 1'b1);

        // H,H,T: error on second head, packet still completes
        q.delete();
        q = {fh, mk(2'b00, 32'h0000_00A1), ft};
        apply_reset();
        cycle(1'b1, 1'b1, 1'b0, rd);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("hh_first_ok", proto_err, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("hh_err", proto_err, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("hh_pkt_cnt", pkt_cnt, 1);
        chk("hh_idle", pkt_active, 1'b0);

        // enable low mid-packet holds ACTIVE and stops pops
        q.delete();
        q = {fh, fb1, ft};
        apply_reset();
        cycle(1'b1, 1'b1, 1'b0, rd);
        cycle(1'b1, 1'b1, 1'b0, rd);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, rd);
            chk("hold_no_pop", rd, 1'b0);
            chk("hold_active", pkt_active, 1'b1);
        end
        cycle(1'b1, 1'b1, 1'b0, rd);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("hold_done", pkt_cnt, 1);

        // Reset after H,B: partial packet is dropped, buffer keeps the rest
        q.delete();
        q = {fh, fb1, fb2, ft};
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, rd);
        chk("mid_active_before", pkt_active, 1'b1);
        apply_reset();
        chk("mid_valid_rst", link_valid, 1'b0);
        chk("mid_active_rst", pkt_active, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("mid_reload_no_pop", rd, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, rd);
        chk("mid_resume_pop", rd, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, rd);
        cycle(1'b1, 1'b1, 1'b0, rd);

        // Saturation: 20 head-tail flits
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(mk(2'b11, 32'(i + 100)));
        apply_reset();
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle(1'b1, 1'b1, 1'b0, rd);
        chk("sat_drained", 64'(q.size()), 0);
        chk("sat_flit16", flit_cnt, 20);
        chk("sat_flit4", flit_cnt4, 15);
        chk("sat_pkt4", pkt_cnt4, 15);

        // Randomized traffic
        q.delete();
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            logic en, dn, clr;
            if (q.size() < 6 && ($urandom % 3) != 0)
                q.push_back(mk(2'($urandom_range(0, 3)), $urandom));
            en  = ($urandom % 8) != 0;
            dn  = ($urandom % 5) != 0;
            clr = ($urandom % 64) == 0;
            if (($urandom % 500) == 0) apply_reset();
            cycle(en, dn, clr, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
